hub75_scan_driver: RTL and testbench
====================================

Name: hub75_scan_driver

Overview:
- Upstream/downstream neighbour of painter24: generates the frame, subframe, x and y stimulus for the painter, consumes its rgb24 result, and drives the HUB75 pins of a 64x64 panel with 1:32 scan.
- Performs PWM by comparing each 8-bit channel against the running subframe counter.
- Time-multiplexes one painter between the top half (rows 0-31) and bottom half (rows 32-63).
- Sits between the top-level pin bundle and painter24; replaces hand-rolled scan logic.

Parameters:
- FRAME_BITS, 13, width of the frame counter output.
- DELAY, 1, painter latency in cycles from x/y change to valid rgb24; legal range 0..3.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous active-low reset.
- frame  output  FRAME_BITS  frame counter to painter.
- subframe  output  8  PWM threshold, also driven to painter.
- x  output  6  pixel column requested from painter.
- y  output  6  pixel row requested from painter.
- rgb24  input  24  painter result {r,g,b}, valid DELAY cycles after x/y.
- rgb_top  output  3  {R0,G0,B0} panel data, top half.
- rgb_bot  output  3  {R1,G1,B1} panel data, bottom half.
- addr  output  5  panel row address.
- sclk  output  1  panel shift clock.
- latch  output  1  panel latch strobe.
- blank  output  1  panel output-enable, active-high blank.

Behaviour:
- Reset (resetn=0 at a clk edge): state=SHIFT, slot=0, row=0, subframe=0, frame=0, x=0, y=0, rgb_top=0, rgb_bot=0, sclk=0, latch=0, blank=1, addr=0. Reset mid-row discards the partial row; no latch is issued.
- Slot counter s[7:0] counts 0..255 in SHIFT. Column c=s[7:2], phase p=s[1:0].
- Request side: x=c always. p=0 gives y={0,row}. p=1,2,3 give y={1,row}.
- Capture side uses s delayed by DELAY cycles (sd; pd=sd[1:0]), so capture aligns with rgb24 validity.
  - pd=0: capture rgb24 as top pixel.
  - pd=1: capture rgb24 as bottom pixel.
  - pd=2: register rgb_top[2]=(r_top>subframe), [1]=(g_top>subframe), [0]=(b_top>subframe); rgb_bot likewise from the bottom pixel; sclk=0.
  - pd=3: sclk=1. Data is stable for 1 cycle of setup and 1 cycle of hold around the rising edge.
  - Comparison is strict: a channel of 0 is never lit; a channel of 255 is lit for 255 of 256 subframes.
- State transitions:
  - SHIFT ends when s=255 and the DELAY-cycle drain has completed (i.e. capture of sd=255 is done). The SHIFT state lasts 256+DELAY cycles.
  - SHIFT -> BLANK: 1 cycle, blank=1, sclk=0.
  - BLANK -> LATCH: 1 cycle, blank=1, latch=1, addr<=row on entry.
  - LATCH -> SHIFT: latch=0, blank=0, s=0, counters advance, start the next row.
- Row period: 258+DELAY cycles. blank stays 0 throughout SHIFT, so the latched row displays while the next row shifts.
- Counter advance on LATCH exit:
  - row+1.
  - On row 31->0, subframe+1.
  - On subframe 255->0, frame+1.
  - frame wraps modulo 2^FRAME_BITS.
- All outputs are registered; no combinational path from rgb24 to the pins.

Test Plan:
- Reset hold then release with painter stub rgb24=0 -> blank=1, addr=0, frame=0 until first LATCH; first latch pulse at cycle 257+DELAY after release; rgb pins 0 throughout.
- Stub rgb24=24'hFF0080, DELAY=1 -> at subframe=0 every column gives rgb_top=rgb_bot=3'b101; once subframe reaches 128, pins are 3'b100; exactly 64 sclk rising edges per row.
- Stub returns a function of y: top=24'hFFFFFF when y<32, bottom=0 -> rgb_top=3'b111, rgb_bot=3'b000 for all columns; confirms top/bottom alignment at DELAY=0 and DELAY=3.
- Run 32 rows -> addr sequence 0..31, then subframe goes 0->1; force subframe=255 at row 31 end -> subframe=0, frame increments by 1.
- Assert resetn=0 at s=100 -> next cycle blank=1, sclk=0, row=0; no latch pulse occurs; normal scan resumes after release.
- Check sclk against data: rgb_top/rgb_bot never change in the cycle sclk rises or in the cycle sclk is high; latch is never high while sclk=1.

Source files
------------

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: 64x64 1:32 HUB75 scan with PWM, sharing one painter between panel halves
module hub75_scan_driver #(
    parameter int FRAME_BITS = 13,
    parameter int DELAY      = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic [FRAME_BITS-1:0] frame,
    output logic [7:0]            subframe,
    output logic [5:0]            x,
    output logic [5:0]            y,
    input  logic [23:0]           rgb24,
    output logic [2:0]            rgb_top,
    output logic [2:0]            rgb_bot,
    output logic [4:0]            addr,
    output logic                  sclk,
    output logic                  latch,
    output logic                  blank
);
    typedef enum logic [1:0] {SHIFT, BLANK, LATCH} state_t;

    state_t      r_state, w_next;
    logic [8:0]  r_cnt;
    logic [4:0]  r_row;
    logic [23:0] r_top, r_bot;
    logic [7:0]  w_s1;
    logic [1:0]  w_pd;
    logic        w_cap, w_done;

    // r_cnt runs 0..255+DELAY; the request slot is r_cnt clamped at 255, the capture slot is r_cnt-DELAY
    assign w_s1   = r_cnt[7:0] + 8'd1;
    assign w_pd   = r_cnt[1:0] - 2'(DELAY);
    assign w_cap  = r_cnt >= 9'(DELAY);
    assign w_done = r_cnt == 9'(255 + DELAY);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= SHIFT;
        else         r_state <= w_next;
    end

    // SHIFT until the last delayed capture, then one BLANK cycle and one LATCH cycle
    always_comb begin
        w_next = (r_state == SHIFT) ? (w_done ? BLANK : SHIFT) :
                 (r_state == BLANK) ? LATCH : SHIFT;
    end

    // Painter requests, pixel capture, PWM compare, shift clock and row/subframe/frame advance
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_row    <= '0;
            r_top    <= '0;
            r_bot    <= '0;
            subframe <= '0;
            frame    <= '0;
            x        <= '0;
            y        <= '0;
            rgb_top  <= '0;
            rgb_bot  <= '0;
            addr     <= '0;
            sclk     <= 1'b0;
            latch    <= 1'b0;
            blank    <= 1'b1;
        end else begin
            case (r_state)
                SHIFT: begin
                    r_cnt <= r_cnt + 9'd1;
                    if (r_cnt < 9'd255) begin
                        x <= w_s1[7:2];
                        y <= {|w_s1[1:0], r_row};
                    end
                    if (w_cap) begin
                        case (w_pd)
                            2'd0: r_top <= rgb24;
                            2'd1: r_bot <= rgb24;
                            2'd2: begin
                                rgb_top <= {r_top[23:16] > subframe, r_top[15:8] > subframe, r_top[7:0] > subframe};
                                rgb_bot <= {r_bot[23:16] > subframe, r_bot[15:8] > subframe, r_bot[7:0] > subframe};
                                sclk    <= 1'b0;
                            end
                            default: sclk <= 1'b1;
                        endcase
                    end
                    if (w_done) blank <= 1'b1;
                end
                BLANK: begin
                    sclk  <= 1'b0;
                    latch <= 1'b1;
                    addr  <= r_row;
                end
                LATCH: begin
                    latch <= 1'b0;
                    blank <= 1'b0;
                    r_cnt <= '0;
                    x     <= '0;
                    y     <= {1'b0, r_row + 5'd1};
                    r_row <= r_row + 5'd1;
                    if (r_row == 5'd31) begin
                        subframe <= subframe + 8'd1;
                        if (subframe == 8'd255) frame <= frame + FRAME_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver: randomized painter image checked against a per-column PWM model
module tb_hub75_scan_driver;
    localparam int D = 1;

    logic        clk = 1'b0, resetn = 1'b0;
    logic [12:0] frame, frame0, frame3;
    logic [7:0]  subframe, subframe0, subframe3;
    logic [5:0]  x, y, x0, y0, x3, y3;
    logic [23:0] rgb24, rgb0, rgb3;
    logic [23:0] p3 [3];
    logic [2:0]  rgb_top, rgb_bot, rgb_top0, rgb_bot0, rgb_top3, rgb_bot3;
    logic [4:0]  addr, addr0, addr3;
    logic        sclk, latch, blank, sclk0, latch0, blank0, sclk3, latch3, blank3;
    logic [23:0] pix [4096];

    int n_chk = 0, n_pass = 0, since = 0, m_row = 0, m_sf = 0, m_frame = 0;
    bit first = 1'b1;

    always #5 clk = ~clk;

    hub75_scan_driver #(.FRAME_BITS(13), .DELAY(D)) dut (
        .clk(clk), .resetn(resetn), .frame(frame), .subframe(subframe), .x(x), .y(y),
        .rgb24(rgb24), .rgb_top(rgb_top), .rgb_bot(rgb_bot), .addr(addr),
        .sclk(sclk), .latch(latch), .blank(blank));

    hub75_scan_driver #(.FRAME_BITS(13), .DELAY(0)) dut0 (
        .clk(clk), .resetn(resetn), .frame(frame0), .subframe(subframe0), .x(x0), .y(y0),
        .rgb24(rgb0), .rgb_top(rgb_top0), .rgb_bot(rgb_bot0), .addr(addr0),
        .sclk(sclk0), .latch(latch0), .blank(blank0));

    hub75_scan_driver #(.FRAME_BITS(13), .DELAY(3)) dut3 (
        .clk(clk), .resetn(resetn), .frame(frame3), .subframe(subframe3), .x(x3), .y(y3),
        .rgb24(rgb3), .rgb_top(rgb_top3), .rgb_bot(rgb_bot3), .addr(addr3),
        .sclk(sclk3), .latch(latch3), .blank(blank3));

    // Painter stubs: image lookup with 1-cycle latency, and top-white/bottom-black at latency 0 and 3
    assign rgb0 = y0[5] ? 24'h0 : 24'hFFFFFF;
    assign rgb3 = p3[2];
    always @(posedge clk) begin
        rgb24 <= pix[{y, x}];
        p3[0] <= y3[5] ? 24'h0 : 24'hFFFFFF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    function automatic logic [2:0] pwm(input logic [23:0] p, input int sf);
        pwm = {int'(p[23:16]) > sf, int'(p[15:8]) > sf, int'(p[7:0]) > sf};
    endfunction

    task automatic tick;
        @(negedge clk);
        since++;
    endtask

    task automatic hold_reset(input int n);
        resetn = 1'b0;
        repeat (n) tick();
    endtask

    task automatic release_reset;
        resetn = 1'b1;
        since = 0;
        first = 1'b1;
        m_row = 0;
        m_sf = 0;
        m_frame = 0;
    endtask

    // Scan rows: the k-th sclk rise of a row must carry column k's PWM bits; latch timing and counters follow
    task automatic scan(input int nrows);
        logic [2:0] pt, pb, et, eb;
        logic ps;
        int k, budget;
        for (int r = 0; r < nrows; r++) begin
            k = 0;
            budget = 0;
            pt = rgb_top;
            pb = rgb_bot;
            ps = sclk;
            while (latch !== 1'b1 && budget < 400) begin
                tick();
                budget++;
                if (sclk === 1'b1) begin
                    n_chk++;
                    if ({rgb_top, rgb_bot} !== {pt, pb})
                        $display("FAIL data_hold row %0d: pins %b/%b changed from %b/%b while sclk high", m_row, rgb_top, rgb_bot, pt, pb);
                    else n_pass++;
                end
                if (sclk === 1'b1 && ps === 1'b0) begin
                    et = pwm(pix[m_row * 64 + (k & 63)], m_sf);
                    eb = pwm(pix[(m_row + 32) * 64 + (k & 63)], m_sf);
                    n_chk++;
                    if ({rgb_top, rgb_bot} !== {et, eb})
                        $display("FAIL pixel row %0d col %0d sf %0d: got %b/%b expected %b/%b", m_row, k, m_sf, rgb_top, rgb_bot, et, eb);
                    else n_pass++;
                    k++;
                end
                if (first) begin
                    n_chk++;
                    if (blank !== 1'b1) $display("FAIL blank_before_first_latch: got %b expected 1", blank);
                    else n_pass++;
                end
                n_chk++;
                if ((latch & sclk) !== 1'b0) $display("FAIL latch_with_sclk: latch %b sclk %b", latch, sclk);
                else n_pass++;
                ps = sclk;
                pt = rgb_top;
                pb = rgb_bot;
            end
            n_chk++;
            if (since != (first ? 257 : 258) + D) $display("FAIL latch_timing row %0d: got cycle %0d expected %0d", m_row, since, (first ? 257 : 258) + D);
            else n_pass++;
            n_chk++;
            if (k != 64) $display("FAIL sclk_count row %0d: got %0d expected 64", m_row, k);
            else n_pass++;
            n_chk++;
            if ({addr, blank} !== {m_row[4:0], 1'b1}) $display("FAIL latch_addr: got addr %0d blank %b expected %0d 1", addr, blank, m_row);
            else n_pass++;
            since = 0;
            first = 1'b0;
            m_row = (m_row + 1) % 32;
            if (m_row == 0) begin
                m_sf = (m_sf + 1) % 256;
                if (m_sf == 0) m_frame = (m_frame + 1) % 8192;
            end
            tick();
            n_chk++;
            if ({subframe, frame, latch, blank} !== {m_sf[7:0], m_frame[12:0], 2'b00})
                $display("FAIL counters: got sf %0d frame %0d latch %b blank %b expected %0d %0d 0 0", subframe, frame, latch, blank, m_sf, m_frame);
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        hold_reset(3);
        n_chk++;
        if ({blank, latch, sclk, addr, rgb_top, rgb_bot, x, y, subframe, frame} !== {3'b100, 5'd0, 6'd0, 12'd0, 8'd0, 13'd0})
            $display("FAIL reset_main: blank %b latch %b sclk %b addr %0d pins %b/%b x %0d y %0d sf %0d frame %0d", blank, latch, sclk, addr, rgb_top, rgb_bot, x, y, subframe, frame);
        else n_pass++;
        n_chk++;
        if ({blank0, latch0, sclk0, addr0, rgb_top0, rgb_bot0, x0, y0, subframe0, frame0} !== {3'b100, 5'd0, 6'd0, 12'd0, 8'd0, 13'd0})
            $display("FAIL reset_d0: got %b", {blank0, latch0, sclk0, addr0, rgb_top0, rgb_bot0, x0, y0, subframe0, frame0});
        else n_pass++;
        n_chk++;
        if ({blank3, latch3, sclk3, addr3, rgb_top3, rgb_bot3, x3, y3, subframe3, frame3} !== {3'b100, 5'd0, 6'd0, 12'd0, 8'd0, 13'd0})
            $display("FAIL reset_d3: got %b", {blank3, latch3, sclk3, addr3, rgb_top3, rgb_bot3, x3, y3, subframe3, frame3});
        else n_pass++;
    endtask

    task automatic test_first_row;
        release_reset();
        scan(2);
    endtask

    task automatic test_delay_align;
        logic ps0, ps3;
        int n0 = 0, n3 = 0;
        hold_reset(2);
        release_reset();
        ps0 = sclk0;
        ps3 = sclk3;
        repeat (800) begin
            tick();
            if (sclk0 === 1'b1 && ps0 === 1'b0) begin
                n0++;
                n_chk++;
                if ({rgb_top0, rgb_bot0} !== 6'b111000) $display("FAIL align_d0 rise %0d: got %b/%b expected 111/000", n0, rgb_top0, rgb_bot0);
                else n_pass++;
            end
            if (sclk3 === 1'b1 && ps3 === 1'b0) begin
                n3++;
                n_chk++;
                if ({rgb_top3, rgb_bot3} !== 6'b111000) $display("FAIL align_d3 rise %0d: got %b/%b expected 111/000", n3, rgb_top3, rgb_bot3);
                else n_pass++;
            end
            ps0 = sclk0;
            ps3 = sclk3;
        end
        n_chk++;
        if (n0 < 128 || n3 < 128) $display("FAIL align_rises: got %0d and %0d expected at least 128 each", n0, n3);
        else n_pass++;
    endtask

    task automatic test_pwm_const;
        hold_reset(2);
        for (int i = 0; i < 4096; i++) pix[i] = 24'hFF0080;
        release_reset();
        scan(2);
        force dut.subframe = 8'd128;
        tick();
        release dut.subframe;
        m_sf = 128;
        scan(2);
    endtask

    task automatic fill_random;
        for (int i = 0; i < 4096; i++) pix[i] = 24'($urandom);
        pix[0] = 24'h000000;
        pix[1] = 24'hFFFFFF;
        pix[2] = 24'h010001;
        pix[32 * 64] = 24'hFFFFFF;
        pix[32 * 64 + 1] = 24'h000000;
        pix[31 * 64] = 24'hFFFFFF;
        pix[31 * 64 + 1] = 24'hFEFF00;
    endtask

    task automatic test_random;
        hold_reset(2);
        fill_random();
        release_reset();
        scan(3);
    endtask

    task automatic test_mid_reset;
        while (since < 101) tick();
        resetn = 1'b0;
        tick();
        n_chk++;
        if ({blank, sclk, latch, addr, y} !== {3'b100, 5'd0, 6'd0})
            $display("FAIL mid_reset: blank %b sclk %b latch %b addr %0d y %0d expected 1 0 0 0 0", blank, sclk, latch, addr, y);
        else n_pass++;
        repeat (3) begin
            tick();
            n_chk++;
            if (latch !== 1'b0) $display("FAIL mid_reset_latch: got %b expected 0", latch);
            else n_pass++;
        end
        release_reset();
        scan(2);
    endtask

    task automatic test_frame_wrap;
        hold_reset(2);
        fill_random();
        release_reset();
        scan(32);
        scan(31);
        force dut.subframe = 8'd255;
        tick();
        release dut.subframe;
        m_sf = 255;
        scan(1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) pix[i] = 24'h0;
        test_reset();
        test_first_row();
        test_delay_align();
        test_pwm_const();
        test_random();
        test_mid_reset();
        test_frame_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
